aes_req_arbiter: RTL and testbench
==================================

Name: aes_req_arbiter

Overview:
- Round-robin scheduler that shares a single aes_192 encryption core among NREQ requesters.
- Each requester presents a plaintext/key pair and a request.
- The block grants one requester at a time, drives the core's state/key/start inputs, and waits for the core's out_valid. It then returns the ciphertext to the granted requester with a done pulse.
- It sits between the per-client register front-ends and the aes_192 instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles spent in RUN before the operation is aborted with error.

Ports:
- wb_clk_i  in  1  clock; all state is updated on the rising edge.
- wb_rst_ni  in  1  asynchronous reset, active low.
- req_i  in  NREQ  per-requester request level.
- pt_i  in  NREQ*128  plaintexts; requester n occupies bits [128n+127:128n].
- key_i  in  NREQ*192  keys; requester n occupies bits [192n+191:192n].
- gnt_o  out  NREQ  one-hot grant, held from LOAD through DONE.
- done_o  out  NREQ  one-cycle completion pulse to the granted requester.
- err_o  out  NREQ  one-cycle timeout flag, coincident with done_o.
- ct_o  out  128  last captured ciphertext.
- busy_o  out  1  high whenever the state is not IDLE.
- aes_state_o  out  128  plaintext driven to the core.
- aes_key_o  out  192  key driven to the core.
- aes_start_o  out  1  start level to the core.
- aes_ct_i  in  128  core output.
- aes_valid_i  in  1  core out_valid.

Behaviour:
- Reset (wb_rst_ni=0, asynchronous):
  - state=IDLE and rr pointer=0.
  - All outputs are 0: gnt_o, done_o, err_o, ct_o, aes_state_o, aes_key_o, aes_start_o, busy_o.
  - Reset asserted mid-operation aborts the operation immediately; no done_o pulse is produced.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - req_i is sampled only in IDLE.
  - If any bit of req_i is set, select the first set bit searching upward from the rr pointer, wrapping modulo NREQ.
  - Register the selected index and copy that requester's pt/key into aes_state_o/aes_key_o.
  - Go to LOAD.
  - If no request is present, stay in IDLE.
- LOAD:
  - gnt_o[idx]=1 and aes_start_o=1.
  - Clear the cycle counter and the seen_low flag.
  - Go to RUN.
- RUN:
  - aes_start_o stays 1 and the counter increments each cycle.
  - seen_low is set in any RUN cycle where aes_valid_i=0.
  - Capture ct_o<=aes_ct_i and go to DONE (err=0) when aes_valid_i=1 and seen_low was already set in an earlier cycle. This rejects a valid level left over from the previous operation.
  - If the counter reaches TIMEOUT-1 with no capture, go to DONE with err=1; ct_o is left unchanged.
  - If a capture and the timeout occur in the same cycle, the capture wins (err=0).
- DONE:
  - aes_start_o=0, done_o[idx]=1 and err_o[idx]=err, each for exactly one cycle; gnt_o[idx] is still 1.
  - rr pointer <= (idx+1) mod NREQ.
  - Go to IDLE.
- Latency: a request seen in IDLE at cycle t gives gnt_o at t+1. If the valid-capture cycle is c, done_o is at c+1.
- Minimum turnaround: from one DONE to the next grant is 2 cycles (DONE to IDLE, then IDLE to LOAD).
- A requester that drops req_i mid-operation does not cancel it; done_o still pulses.
- Changes on pt_i/key_i after the IDLE sample do not affect the operation in flight.
- ct_o holds its value until the next successful capture.
- done_o and err_o are never asserted for more than one requester in any cycle.

Test Plan:
- FIPS-197 AES-192 vector, requester 0 only:
  - key 000102030405060708090a0b0c0d0e0f1011121314151617, pt 00112233445566778899aabbccddeeff, core model with 20-cycle latency.
  - Required: gnt_o=0001, then done_o[0] pulse, ct_o=dda97ca4864cdfe06eaf70a0ec0d7191, err_o=0.
- All four requests asserted continuously:
  - Required grant order 0,1,2,3,0; each done_o pulse goes to the matching requester; 2-cycle gap between DONE and the next LOAD.
- Stale valid:
  - Core model holds aes_valid_i=1 from the previous operation for 3 RUN cycles, then drops it, then raises it with new ct.
  - Required: capture occurs only on the second rise.
- Timeout:
  - Core never asserts aes_valid_i, TIMEOUT=64.
  - Required: done_o and err_o pulse 64 cycles after LOAD; ct_o unchanged.
- Requester 2 deasserts req_i during RUN:
  - Required: the operation completes and done_o[2] pulses.
- wb_rst_ni pulsed low mid-RUN:
  - Required: all outputs go to 0 asynchronously; no done_o; the first grant after release goes to requester 0.

Source files
------------

// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one aes_192 core among NREQ requesters; grant 1 cycle after an IDLE request,
// done 1 cycle after a valid capture (or TIMEOUT cycles after LOAD); requesters wait on level req with no backpressure path.
module aes_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*128-1:0]  pt_i,
    input  logic [NREQ*192-1:0]  key_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      done_o,
    output logic [NREQ-1:0]      err_o,
    output logic [127:0]         ct_o,
    output logic                 busy_o,
    output logic [127:0]         aes_state_o,
    output logic [191:0]         aes_key_o,
    output logic                 aes_start_o,
    input  logic [127:0]         aes_ct_i,
    input  logic                 aes_valid_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t         state;
    logic [IW-1:0]  rr;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  sel;
    logic           sel_vld;
    logic [IW:0]    j;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;
    logic           seen_low;
    logic [127:0]   pt_arr  [NREQ];
    logic [191:0]   key_arr [NREQ];

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_slot
            assign pt_arr[g]  = pt_i[128*g +: 128];
            assign key_arr[g] = key_i[192*g +: 192];
        end
    endgenerate

    // First set request at or above rr, wrapping modulo NREQ.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        j       = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = {1'b0, rr} + (IW+1)'(i);
            if (j >= (IW+1)'(NREQ)) j = j - (IW+1)'(NREQ);
            if (!sel_vld && req_i[j[IW-1:0]]) begin
                sel     = j[IW-1:0];
                sel_vld = 1'b1;
            end
        end
    end

    assign cnt_inc = cnt + CW'(1);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            rr          <= '0;
            idx         <= '0;
            cnt         <= '0;
            seen_low    <= 1'b0;
            gnt_o       <= '0;
            done_o      <= '0;
            err_o       <= '0;
            ct_o        <= '0;
            busy_o      <= 1'b0;
            aes_state_o <= '0;
            aes_key_o   <= '0;
            aes_start_o <= 1'b0;
        end else begin
            done_o <= '0;
            err_o  <= '0;
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        idx         <= sel;
                        aes_state_o <= pt_arr[sel];
                        aes_key_o   <= key_arr[sel];
                        gnt_o       <= NREQ'(1) << sel;
                        aes_start_o <= 1'b1;
                        busy_o      <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    cnt      <= '0;
                    seen_low <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    cnt <= cnt_inc;
                    if (!aes_valid_i) seen_low <= 1'b1;
                    // A valid only counts once a low was seen earlier, so a level left over from the last op is ignored.
                    if (aes_valid_i && seen_low) begin
                        ct_o        <= aes_ct_i;
                        done_o      <= gnt_o;
                        aes_start_o <= 1'b0;
                        state       <= DONE;
                    end else if (cnt_inc == CW'(TIMEOUT - 1)) begin
                        done_o      <= gnt_o;
                        err_o       <= gnt_o;
                        aes_start_o <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    gnt_o  <= '0;
                    busy_o <= 1'b0;
                    rr     <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Randomised bench for aes_req_arbiter against a transaction-level reference model and a mock AES core.
module tb_aes_req_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam logic [191:0] FIPS_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_ni;
    logic [NREQ-1:0]     req_i;
    logic [NREQ*128-1:0] pt_i;
    logic [NREQ*192-1:0] key_i;
    logic [NREQ-1:0]     gnt_o, done_o, err_o;
    logic [127:0]        ct_o, aes_state_o, aes_ct_i;
    logic [191:0]        aes_key_o;
    logic                busy_o, aes_start_o, aes_valid_i;

    always #5 wb_clk_i = ~wb_clk_i;

    aes_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .req_i(req_i), .pt_i(pt_i), .key_i(key_i),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .ct_o(ct_o), .busy_o(busy_o),
        .aes_state_o(aes_state_o), .aes_key_o(aes_key_o), .aes_start_o(aes_start_o),
        .aes_ct_i(aes_ct_i), .aes_valid_i(aes_valid_i)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Mock core: known FIPS-197 answer for the standard vector, a keyed mix otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [191:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return pt ^ key[127:0] ^ {key[191:128], key[191:128]} ^ 128'h5a5a_1234_a5a5_4321_0f0f_9876_f0f0_6789;
    endfunction

    // Cycles from LOAD to the done pulse, and the error flag, for a core that shows a stale valid
    // for its first `stale` start cycles and a real valid from start cycle `lat` on (lat=0: never).
    function automatic void op_timing(input int lat, input int stale, output int delay, output bit err);
        bit seen;
        bit v;
        seen = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) begin
            v = ((k + 1) <= stale) || (lat > 0 && (k + 1) >= lat);
            if (v && seen) begin
                delay = k + 1;
                err = 1'b0;
                return;
            end
            if (!v) seen = 1'b1;
        end
        delay = TIMEOUT;
        err = 1'b1;
    endfunction

    // Core model state
    int           rc, cfg_lat, cfg_stale, cur_lat, cur_stale;
    logic [127:0] stale_ct;
    // Reference model state
    bit           m_active, m_err;
    int           m_idx, m_load, m_done, m_rr, cyc;
    logic [127:0] m_ct, m_pt;
    logic [191:0] m_key;
    // Observations of the DUT
    int              obs_load, obs_idx, obs_done;
    bit              obs_err;
    logic [NREQ-1:0] obs_done_vec, prev_gnt;
    int              grant_log[$];

    task automatic step();
        logic [NREQ-1:0]     s_req;
        logic [NREQ*128-1:0] s_pt;
        logic [NREQ*192-1:0] s_key;
        logic [NREQ-1:0]     oh;
        int d;
        bit e;
        bit found;
        s_req = req_i;
        s_pt  = pt_i;
        s_key = key_i;
        @(posedge wb_clk_i);
        #1;
        cyc++;
        if (aes_start_o) rc++; else rc = 0;
        if (rc == 1) begin
            cur_lat   = cfg_lat;
            cur_stale = cfg_stale;
        end
        if (rc > 0 && rc <= cur_stale) begin
            aes_valid_i = 1'b1;
            aes_ct_i    = stale_ct;
        end else if (rc > 0 && cur_lat > 0 && rc >= cur_lat) begin
            aes_valid_i = 1'b1;
            aes_ct_i    = core_fn(aes_state_o, aes_key_o);
        end else begin
            aes_valid_i = 1'b0;
            aes_ct_i    = '0;
        end
        if (m_active) begin
            if (cyc == m_done + 1) m_active = 1'b0;
        end else if (s_req != '0) begin
            found = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!found && s_req[(m_rr + i) % NREQ]) begin
                    m_idx = (m_rr + i) % NREQ;
                    found = 1'b1;
                end
            end
            op_timing(cfg_lat, cfg_stale, d, e);
            m_active = 1'b1;
            m_load   = cyc;
            m_done   = cyc + d;
            m_err    = e;
            m_pt     = s_pt[128*m_idx +: 128];
            m_key    = s_key[192*m_idx +: 192];
            m_rr     = (m_idx + 1) % NREQ;
        end
        if (m_active && cyc == m_done && !m_err) m_ct = core_fn(m_pt, m_key);
        oh = m_active ? (NREQ'(1) << m_idx) : '0;
        chk("gnt", 256'(gnt_o), 256'(oh));
        chk("busy", 256'(busy_o), 256'(m_active));
        chk("start", 256'(aes_start_o), 256'(m_active && cyc < m_done));
        chk("done", 256'(done_o), 256'((m_active && cyc == m_done) ? oh : '0));
        chk("err", 256'(err_o), 256'((m_active && cyc == m_done && m_err) ? oh : '0));
        chk("ct", 256'(ct_o), 256'(m_ct));
        if (m_active) begin
            chk("aes_state", 256'(aes_state_o), 256'(m_pt));
            chk("aes_key", 256'(aes_key_o), 256'(m_key));
        end
        if (gnt_o != '0 && prev_gnt == '0) begin
            obs_load = cyc;
            for (int i = 0; i < NREQ; i++) if (gnt_o[i]) obs_idx = i;
            grant_log.push_back(obs_idx);
        end
        if (done_o != '0) begin
            obs_done     = cyc;
            obs_err      = |err_o;
            obs_done_vec = done_o;
        end
        prev_gnt = gnt_o;
    endtask

    task automatic async_reset();
        @(posedge wb_clk_i);
        #4;
        wb_rst_ni = 1'b0;
        #1;
        chk("rst_gnt", 256'(gnt_o), 256'(0));
        chk("rst_done", 256'(done_o), 256'(0));
        chk("rst_err", 256'(err_o), 256'(0));
        chk("rst_ct", 256'(ct_o), 256'(0));
        chk("rst_state", 256'(aes_state_o), 256'(0));
        chk("rst_key", 256'(aes_key_o), 256'(0));
        chk("rst_start", 256'(aes_start_o), 256'(0));
        chk("rst_busy", 256'(busy_o), 256'(0));
        aes_valid_i = 1'b0;
        rc = 0;
        repeat (2) begin
            @(posedge wb_clk_i);
            #1;
            chk("rst_hold_done", 256'(done_o), 256'(0));
            chk("rst_hold_gnt", 256'(gnt_o), 256'(0));
        end
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        m_active = 1'b0;
        m_rr     = 0;
        m_ct     = '0;
        prev_gnt = '0;
    endtask

    task automatic run_idle(input int max);
        int n;
        n = 0;
        while ((m_active || busy_o) && n < max) begin
            step();
            n++;
        end
        chk("idle_bound", 256'(n < max), 256'(1));
    endtask

    task automatic wait_active(input int max);
        int n;
        n = 0;
        while (!m_active && n < max) begin
            step();
            n++;
        end
        chk("grant_bound", 256'(m_active), 256'(1));
    endtask

    task automatic single_op(input logic [NREQ-1:0] r);
        req_i = r;
        wait_active(10);
        req_i = '0;
        run_idle(200);
    endtask

    task automatic rand_data();
        for (int w = 0; w < NREQ * 4; w++) pt_i[32*w +: 32] = $urandom();
        for (int w = 0; w < NREQ * 6; w++) key_i[32*w +: 32] = $urandom();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_order[5];
        int n;
        logic [127:0] ct_before;
        exp_order = '{0, 1, 2, 3, 0};
        wb_rst_ni = 1'b0;
        req_i = '0; pt_i = '0; key_i = '0;
        aes_ct_i = '0; aes_valid_i = 1'b0;
        cfg_lat = 20; cfg_stale = 0; cur_lat = 0; cur_stale = 0; rc = 0; cyc = 0;
        stale_ct = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        m_active = 1'b0; m_ct = '0; m_rr = 0; prev_gnt = '0;
        obs_load = 0; obs_done = 0; obs_idx = 0; obs_err = 1'b0; obs_done_vec = '0;
        async_reset();
        repeat (3) step();

        // FIPS-197 AES-192 vector on requester 0
        pt_i[127:0] = FIPS_PT;
        key_i[191:0] = FIPS_KEY;
        cfg_lat = 20;
        req_i = 4'b0001;
        step();
        chk("fips_gnt", 256'(gnt_o), 256'(4'b0001));
        req_i = '0;
        run_idle(200);
        chk("fips_ct", 256'(ct_o), 256'(FIPS_CT));
        chk("fips_err", 256'(obs_err), 256'(0));
        chk("fips_done_vec", 256'(obs_done_vec), 256'(4'b0001));
        chk("fips_lat", 256'(obs_done - obs_load), 256'(20));

        // All requesters continuously: order and turnaround
        async_reset();
        grant_log.delete();
        rand_data();
        cfg_lat = 5;
        req_i = 4'hf;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (grant_log.size() <= g && n < 100) begin
                step();
                n++;
            end
            chk("rr_bound", 256'(n < 100), 256'(1));
            if (grant_log.size() > g) chk("rr_idx", 256'(grant_log[g]), 256'(exp_order[g]));
            if (g > 0) chk("rr_gap", 256'(obs_load - obs_done), 256'(2));
        end
        req_i = '0;
        run_idle(200);

        // Stale valid for 3 RUN cycles, real result at start cycle 10
        cfg_stale = 4;
        cfg_lat = 10;
        single_op(4'b1000);
        chk("stale_lat", 256'(obs_done - obs_load), 256'(10));
        chk("stale_err", 256'(obs_err), 256'(0));
        chk("stale_ct", 256'(ct_o), 256'(core_fn(pt_i[3*128 +: 128], key_i[3*192 +: 192])));
        cfg_stale = 0;

        // Timeout
        ct_before = ct_o;
        cfg_lat = 0;
        single_op(4'b0001);
        chk("to_lat", 256'(obs_done - obs_load), 256'(TIMEOUT));
        chk("to_err", 256'(obs_err), 256'(1));
        chk("to_ct", 256'(ct_o), 256'(ct_before));

        // Valid arrives on the last RUN cycle: capture beats timeout
        cfg_lat = TIMEOUT;
        single_op(4'b0010);
        chk("edge_lat", 256'(obs_done - obs_load), 256'(TIMEOUT));
        chk("edge_err", 256'(obs_err), 256'(0));

        // Requester 2 drops its request mid-RUN
        cfg_lat = 15;
        req_i = 4'b0100;
        wait_active(10);
        repeat (3) step();
        req_i = '0;
        run_idle(200);
        chk("drop_idx", 256'(obs_idx), 256'(2));
        chk("drop_done_vec", 256'(obs_done_vec), 256'(4'b0100));

        // Reset mid-RUN with rr pointing away from 0
        cfg_lat = 30;
        req_i = 4'b0010;
        wait_active(10);
        req_i = '0;
        repeat (5) step();
        async_reset();
        req_i = 4'hf;
        wait_active(10);
        chk("rst_first_idx", 256'(obs_idx), 256'(0));
        req_i = '0;
        run_idle(200);

        // Random traffic with data churn during operations
        for (int it = 0; it < 40; it++) begin
            cfg_lat   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 70));
            cfg_stale = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            req_i     = NREQ'($urandom_range(0, 15));
            n = int'($urandom_range(1, 20));
            for (int s = 0; s < n; s++) begin
                step();
                rand_data();
            end
        end
        req_i = '0;
        run_idle(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
